// File: rtl/sd_spi_byte_engine.sv
// SPI mode-0 byte engine for SD cards: shifts one byte out on mosi while capturing one from miso.
// Optional slow-clock divisor (slow_mode port, SLOW_DIV parameter) enabled by SD_SPI_SLOW_CLK_EN.
module sd_spi_byte_engine #(
  parameter int FAST_DIV = 1
`ifdef SD_SPI_SLOW_CLK_EN
  ,
  parameter int SLOW_DIV = 64
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       execute,
  input  logic [7:0] out_word,
  input  logic       miso,
`ifdef SD_SPI_SLOW_CLK_EN
  input  logic       slow_mode,
`endif
  output logic       spi_clk,
  output logic       mosi,
  output logic [7:0] in_word,
  output logic       finished,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, LOW_HALF, HIGH_HALF, DONE} state_t;

  state_t     state;
  logic [7:0] div_q;
  logic [7:0] half_cnt;
  logic [6:0] tx_sh;
  logic [7:0] rx_sh;
  logic [2:0] bit_cnt;
  logic [7:0] div_sel;
  logic       half_end;

  always_comb begin
`ifdef SD_SPI_SLOW_CLK_EN
    div_sel = slow_mode ? 8'(SLOW_DIV) : 8'(FAST_DIV);
`else
    div_sel = 8'(FAST_DIV);
`endif
  end

  assign half_end = (half_cnt == div_q - 8'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      div_q    <= 8'd1;
      half_cnt <= 8'd0;
      tx_sh    <= 7'd0;
      rx_sh    <= 8'd0;
      bit_cnt  <= 3'd0;
      spi_clk  <= 1'b0;
      mosi     <= 1'b1;
      in_word  <= 8'h00;
      finished <= 1'b0;
      busy     <= 1'b0;
    end else begin
      finished <= 1'b0;
      case (state)
        // DONE accepts a new request too, so back-to-back bytes need no extra idle cycle
        IDLE, DONE: begin
          if (execute) begin
            state    <= LOW_HALF;
            div_q    <= div_sel;
            tx_sh    <= out_word[6:0];
            mosi     <= out_word[7];
            busy     <= 1'b1;
            bit_cnt  <= 3'd0;
            half_cnt <= 8'd0;
          end else begin
            state <= IDLE;
          end
        end
        LOW_HALF: begin
          if (half_end) begin
            spi_clk  <= 1'b1;
            rx_sh    <= {rx_sh[6:0], miso};
            half_cnt <= 8'd0;
            state    <= HIGH_HALF;
          end else begin
            half_cnt <= half_cnt + 8'd1;
          end
        end
        HIGH_HALF: begin
          if (half_end) begin
            spi_clk  <= 1'b0;
            half_cnt <= 8'd0;
            if (bit_cnt != 3'd7) begin
              bit_cnt <= bit_cnt + 3'd1;
              mosi    <= tx_sh[6];
              tx_sh   <= {tx_sh[5:0], 1'b0};
              state   <= LOW_HALF;
            end else begin
              // rx_sh already holds the eighth sample taken on the last rising edge
              in_word  <= rx_sh;
              finished <= 1'b1;
              busy     <= 1'b0;
              mosi     <= 1'b1;
              state    <= DONE;
            end
          end else begin
            half_cnt <= half_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
